regfile_wb_arbiter: RTL and testbench
=====================================

// Module: regfile_wb_arbiter
// PURPOSE
// - Write-back end of the register file: drives its single write port (we/waddr/wdata).
// - Merges two result sources:
//   - in-order ALU results (no backpressure);
//   - out-of-order load returns (valid/ready handshake, queued).
// - Keeps a per-register busy scoreboard of outstanding loads and raises a read-hazard stall for decode.
// PARAMETERS
// - LQ_DEPTH      4  load-return queue entries; power of 2, >=2
// - STARVE_LIMIT  8  consecutive cycles a non-empty queue may lose arbitration before o_wb_hold
// PORTS
// - i_clk          in   1   clock, all state updates on posedge
// - i_rst_n        in   1   asynchronous active-low reset
// - i_ld_issue     in   1   load issued this cycle; marks i_ld_issue_rd busy
// - i_ld_issue_rd  in   5   destination of the issued load
// - i_alu_valid    in   1   ALU result valid this cycle (cannot be stalled)
// - i_alu_rd       in   5   ALU destination
// - i_alu_data     in   32  ALU result
// - i_ld_valid     in   1   load return valid
// - i_ld_rd        in   5   load return destination
// - i_ld_data      in   32  load return data
// - o_ld_ready     out  1   queue can accept a load return this cycle
// - i_raddr1/2     in   5   decode read addresses, checked for hazards
// - i_rf_rdata1/2  in   32  register file read data
// - o_rdata1/2     out  32  read data delivered to decode (see CONFIGURATION)
// - o_stall        out  1   read hazard on a busy register
// - o_wb_hold      out  1   request a one-cycle ALU bubble (anti-starvation)
// - o_we           out  1   register file write enable
// - o_waddr        out  5   register file write address
// - o_wdata        out  32  register file write data
// BEHAVIOUR
// - Reset values: o_we=0, o_waddr=0, o_wdata=0, o_wb_hold=0; queue empty (o_ld_ready=1); busy all 0; starve count 0.
// - Load queue: FIFO of LQ_DEPTH entries {rd,data}.
//   - Push when i_ld_valid && o_ld_ready.
//   - o_ld_ready = !full, combinational from registered state.
//   - Pointers wrap modulo LQ_DEPTH.
//   - Push and pop in the same cycle when full: the pop frees a slot only next cycle; ready stays 0 this cycle.
// - Arbitration, each cycle:
//   - ALU wins when i_alu_valid && i_alu_rd!=0.
//   - Otherwise pop the queue head if the queue is non-empty.
//   - A queue head with rd==0 is popped and discarded (no write).
//   - An ALU result with rd==0 is dropped; the queue may use that slot.
// - Write port: the chosen write is registered.
//   - o_we/o_waddr/o_wdata are valid the cycle after selection.
//   - Fixed 1-cycle latency; o_we=0 in idle cycles.
// - Scoreboard: busy[31:1]; busy[0] is hardwired 0.
//   - Set on i_ld_issue for rd!=0.
//   - Cleared in the cycle the queue head for that rd is popped.
//   - Same-cycle set and clear on the same rd: set wins (the newer load is outstanding).
//   - An ALU write to a busy register writes normally and leaves busy unchanged.
// - o_stall = (i_raddr1!=0 && busy[i_raddr1]) || (i_raddr2!=0 && busy[i_raddr2]).
//   - Combinational; uses registered busy only.
// - Starvation counter:
//   - Increments each cycle the queue is non-empty and the ALU takes the port.
//   - Clears on any pop or when the queue is empty.
//   - Saturates at STARVE_LIMIT.
//   - o_wb_hold is registered: 1 while count==STARVE_LIMIT.
//   - The pipeline must drop i_alu_valid the cycle after o_wb_hold=1.
// - Asynchronous reset mid-operation: queued loads and busy bits are discarded; the issuer re-issues.
// CONFIGURATION
// - REGFILE_WB_FWD_EN defined: same-cycle write forwarding.
//   - o_rdataN = o_wdata when o_we && o_waddr==i_raddrN && i_raddrN!=0; else i_rf_rdataN.
//   - Covers the regfile write landing at the same posedge as the read.
// - Not defined: o_rdataN = i_rf_rdataN (pass-through); the port list is identical.
// TESTING
// - Reset: i_rst_n=0 with random inputs -> o_we=0, o_ld_ready=1, o_stall=0, o_wb_hold=0.
// - ALU write: i_alu_valid=1, rd=5, data=32'hDEADBEEF -> next cycle o_we=1, o_waddr=5, o_wdata=32'hDEADBEEF.
//   - rd=0 -> o_we stays 0.
// - Load hazard:
//   - Issue load rd=7, then i_raddr1=7 -> o_stall=1.
//   - Return rd=7, data=32'h1234 with the ALU idle -> busy cleared on pop; o_stall=0 next cycle; write of 32'h1234 to r7.
// - Queue full: 4 returns while i_alu_valid=1 (rd=1) every cycle -> o_ld_ready=0 after the 4th push.
//   - A 5th return is held, not lost.
// - Starvation: keep ALU valid -> o_wb_hold=1 after 8 lost cycles; ALU bubble -> head popped, counter cleared, o_wb_hold=0.
// - Forwarding (REGFILE_WB_FWD_EN): o_we=1, o_waddr=3, o_wdata=32'hA5A5, i_raddr2=3, i_rf_rdata2=0 -> o_rdata2=32'hA5A5.
//   - Without the macro -> o_rdata2=0.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-back arbiter: ALU results win the single write port, queued load returns fill the gaps.
// Optional same-cycle read forwarding is enabled by defining REGFILE_WB_FWD_EN.
module regfile_wb_arbiter #(
  parameter int LQ_DEPTH     = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_ld_issue,
  input  logic [4:0]  i_ld_issue_rd,
  input  logic        i_alu_valid,
  input  logic [4:0]  i_alu_rd,
  input  logic [31:0] i_alu_data,
  input  logic        i_ld_valid,
  input  logic [4:0]  i_ld_rd,
  input  logic [31:0] i_ld_data,
  output logic        o_ld_ready,
  input  logic [4:0]  i_raddr1,
  input  logic [4:0]  i_raddr2,
  input  logic [31:0] i_rf_rdata1,
  input  logic [31:0] i_rf_rdata2,
  output logic [31:0] o_rdata1,
  output logic [31:0] o_rdata2,
  output logic        o_stall,
  output logic        o_wb_hold,
  output logic        o_we,
  output logic [4:0]  o_waddr,
  output logic [31:0] o_wdata
);

  localparam int PW = $clog2(LQ_DEPTH);
  localparam int CW = $clog2(LQ_DEPTH + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [PW-1:0] PTR_ONE    = PW'(1);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic [CW-1:0] CNT_FULL   = CW'(LQ_DEPTH);
  localparam logic [SW-1:0] STARVE_ONE = SW'(1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  logic [4:0]    lq_rd_reg   [LQ_DEPTH];
  logic [31:0]   lq_data_reg [LQ_DEPTH];
  logic [PW-1:0] lq_wr_ptr_reg, lq_rd_ptr_reg;
  logic [CW-1:0] lq_cnt_reg, lq_cnt_next;
  logic [SW-1:0] starve_cnt_reg, starve_cnt_next;
  logic [31:0]   busy_reg, busy_next;
  logic          hold_reg;
  logic          we_reg, we_next;
  logic [4:0]    waddr_reg, waddr_next;
  logic [31:0]   wdata_reg, wdata_next;

  logic        lq_full, lq_empty, lq_push, lq_pop, alu_win;
  logic [4:0]  head_rd;
  logic [31:0] head_data;

  assign lq_full    = (lq_cnt_reg == CNT_FULL);
  assign lq_empty   = (lq_cnt_reg == '0);
  assign o_ld_ready = !lq_full;
  assign lq_push    = i_ld_valid && !lq_full;
  assign alu_win    = i_alu_valid && (i_alu_rd != 5'd0);
  assign lq_pop     = !lq_empty && !alu_win;
  assign head_rd    = lq_rd_reg[lq_rd_ptr_reg];
  assign head_data  = lq_data_reg[lq_rd_ptr_reg];

  // Queue storage has no reset; only the pointers and count define validity.
  always_ff @(posedge i_clk) begin
    if (lq_push) begin
      lq_rd_reg[lq_wr_ptr_reg]   <= i_ld_rd;
      lq_data_reg[lq_wr_ptr_reg] <= i_ld_data;
    end
  end

  always_comb begin
    lq_cnt_next = lq_cnt_reg;
    case ({lq_push, lq_pop})
      2'b10:   lq_cnt_next = lq_cnt_reg + CNT_ONE;
      2'b01:   lq_cnt_next = lq_cnt_reg - CNT_ONE;
      default: lq_cnt_next = lq_cnt_reg;
    endcase
  end

  // Discarded rd==0 heads still pop, they just never reach the write port.
  always_comb begin
    we_next    = 1'b0;
    waddr_next = waddr_reg;
    wdata_next = wdata_reg;
    if (alu_win) begin
      we_next    = 1'b1;
      waddr_next = i_alu_rd;
      wdata_next = i_alu_data;
    end else if (lq_pop && (head_rd != 5'd0)) begin
      we_next    = 1'b1;
      waddr_next = head_rd;
      wdata_next = head_data;
    end
  end

  always_comb begin
    if (lq_empty || lq_pop)
      starve_cnt_next = '0;
    else if (starve_cnt_reg != STARVE_MAX)
      starve_cnt_next = starve_cnt_reg + STARVE_ONE;
    else
      starve_cnt_next = starve_cnt_reg;
  end

  // A new issue to the same rd outranks the pop of an older return.
  assign busy_next[0] = 1'b0;
  generate
    for (genvar gi = 1; gi < 32; gi++) begin : g_busy
      assign busy_next[gi] = (i_ld_issue && (i_ld_issue_rd == 5'(gi))) ? 1'b1 :
                             (lq_pop && (head_rd == 5'(gi)))          ? 1'b0 :
                                                                        busy_reg[gi];
    end
  endgenerate

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      lq_wr_ptr_reg  <= '0;
      lq_rd_ptr_reg  <= '0;
      lq_cnt_reg     <= '0;
      starve_cnt_reg <= '0;
      hold_reg       <= 1'b0;
      busy_reg       <= '0;
      we_reg         <= 1'b0;
      waddr_reg      <= '0;
      wdata_reg      <= '0;
    end else begin
      if (lq_push) lq_wr_ptr_reg <= lq_wr_ptr_reg + PTR_ONE;
      if (lq_pop)  lq_rd_ptr_reg <= lq_rd_ptr_reg + PTR_ONE;
      lq_cnt_reg     <= lq_cnt_next;
      starve_cnt_reg <= starve_cnt_next;
      hold_reg       <= (starve_cnt_next == STARVE_MAX);
      busy_reg       <= busy_next;
      we_reg         <= we_next;
      waddr_reg      <= waddr_next;
      wdata_reg      <= wdata_next;
    end
  end

  assign o_stall   = ((i_raddr1 != 5'd0) && busy_reg[i_raddr1]) ||
                     ((i_raddr2 != 5'd0) && busy_reg[i_raddr2]);
  assign o_wb_hold = hold_reg;
  assign o_we      = we_reg;
  assign o_waddr   = waddr_reg;
  assign o_wdata   = wdata_reg;

`ifdef REGFILE_WB_FWD_EN
  // The write being presented now lands at the same edge decode samples its read.
  assign o_rdata1 = (we_reg && (waddr_reg == i_raddr1) && (i_raddr1 != 5'd0)) ? wdata_reg : i_rf_rdata1;
  assign o_rdata2 = (we_reg && (waddr_reg == i_raddr2) && (i_raddr2 != 5'd0)) ? wdata_reg : i_rf_rdata2;
`else
  assign o_rdata1 = i_rf_rdata1;
  assign o_rdata2 = i_rf_rdata2;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed steps followed by random traffic against a queue-based model.
module tb_regfile_wb_arbiter;
  localparam int LQ_DEPTH     = 4;
  localparam int STARVE_LIMIT = 8;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_ld_issue = 1'b0;
  logic [4:0]  i_ld_issue_rd = '0;
  logic        i_alu_valid = 1'b0;
  logic [4:0]  i_alu_rd = '0;
  logic [31:0] i_alu_data = '0;
  logic        i_ld_valid = 1'b0;
  logic [4:0]  i_ld_rd = '0;
  logic [31:0] i_ld_data = '0;
  logic        o_ld_ready;
  logic [4:0]  i_raddr1 = '0, i_raddr2 = '0;
  logic [31:0] i_rf_rdata1 = '0, i_rf_rdata2 = '0;
  logic [31:0] o_rdata1, o_rdata2;
  logic        o_stall, o_wb_hold, o_we;
  logic [4:0]  o_waddr;
  logic [31:0] o_wdata;

  always #5 i_clk = ~i_clk;

  regfile_wb_arbiter #(.LQ_DEPTH(LQ_DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_ld_issue(i_ld_issue), .i_ld_issue_rd(i_ld_issue_rd),
    .i_alu_valid(i_alu_valid), .i_alu_rd(i_alu_rd), .i_alu_data(i_alu_data),
    .i_ld_valid(i_ld_valid), .i_ld_rd(i_ld_rd), .i_ld_data(i_ld_data),
    .o_ld_ready(o_ld_ready),
    .i_raddr1(i_raddr1), .i_raddr2(i_raddr2),
    .i_rf_rdata1(i_rf_rdata1), .i_rf_rdata2(i_rf_rdata2),
    .o_rdata1(o_rdata1), .o_rdata2(o_rdata2),
    .o_stall(o_stall), .o_wb_hold(o_wb_hold),
    .o_we(o_we), .o_waddr(o_waddr), .o_wdata(o_wdata)
  );

  // Reference model: a queue of pending returns, a busy bitmap, a lost-cycle tally and the pending write.
  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  ent_t        q[$];
  bit [31:0]   busy_m;
  int          lost_m;
  logic        we_m;
  logic [4:0]  waddr_m;
  logic [31:0] wdata_m;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    busy_m  = '0;
    lost_m  = 0;
    we_m    = 1'b0;
    waddr_m = '0;
    wdata_m = '0;
  endtask

  function automatic logic [31:0] exp_rdata(input logic [4:0] ra, input logic [31:0] rf);
`ifdef REGFILE_WB_FWD_EN
    if (we_m && (waddr_m == ra) && (ra != 5'd0)) return wdata_m;
`endif
    return rf;
  endfunction

  task automatic idle_inputs();
    i_ld_issue = 1'b0; i_alu_valid = 1'b0; i_ld_valid = 1'b0;
    i_raddr1 = '0; i_raddr2 = '0;
  endtask

  // One clock: check outputs against the model, advance the model, cross the posedge.
  task automatic cycle();
    ent_t        h;
    bit          nonempty, alu_takes, popping, ready_e, stall_e;
    logic        n_we;
    logic [4:0]  n_waddr;
    logic [31:0] n_wdata;
    #1;
    ready_e = (q.size() < LQ_DEPTH);
    stall_e = ((i_raddr1 != 5'd0) && busy_m[i_raddr1]) || ((i_raddr2 != 5'd0) && busy_m[i_raddr2]);
    chk("ld_ready", 32'(o_ld_ready), 32'(ready_e));
    chk("stall", 32'(o_stall), 32'(stall_e));
    chk("wb_hold", 32'(o_wb_hold), 32'(lost_m == STARVE_LIMIT));
    chk("we", 32'(o_we), 32'(we_m));
    if (we_m) begin
      chk("waddr", 32'(o_waddr), 32'(waddr_m));
      chk("wdata", o_wdata, wdata_m);
    end
    chk("rdata1", o_rdata1, exp_rdata(i_raddr1, i_rf_rdata1));
    chk("rdata2", o_rdata2, exp_rdata(i_raddr2, i_rf_rdata2));

    nonempty  = (q.size() != 0);
    alu_takes = i_alu_valid && (i_alu_rd != 5'd0);
    popping   = nonempty && !alu_takes;
    n_we = 1'b0; n_waddr = waddr_m; n_wdata = wdata_m;
    if (alu_takes) begin
      n_we = 1'b1; n_waddr = i_alu_rd; n_wdata = i_alu_data;
    end else if (popping) begin
      h = q.pop_front();
      busy_m[h.rd] = 1'b0;
      if (h.rd != 5'd0) begin
        n_we = 1'b1; n_waddr = h.rd; n_wdata = h.data;
      end
    end
    if (i_ld_issue && (i_ld_issue_rd != 5'd0)) busy_m[i_ld_issue_rd] = 1'b1;
    busy_m[0] = 1'b0;
    if (i_ld_valid && ready_e) q.push_back('{i_ld_rd, i_ld_data});
    if (!nonempty || popping) lost_m = 0;
    else if (lost_m < STARVE_LIMIT) lost_m++;

    @(posedge i_clk);
    we_m = n_we; waddr_m = n_waddr; wdata_m = n_wdata;
    @(negedge i_clk);
  endtask

  initial begin
    logic [31:0] fwd_exp;
    bit          seen20;

    // Reset with random inputs on every port
    model_reset();
    i_ld_issue = 1'b1; i_ld_issue_rd = 5'($urandom);
    i_alu_valid = 1'b1; i_alu_rd = 5'($urandom); i_alu_data = $urandom;
    i_ld_valid = 1'b1; i_ld_rd = 5'($urandom); i_ld_data = $urandom;
    i_raddr1 = 5'($urandom); i_raddr2 = 5'($urandom);
    repeat (2) @(negedge i_clk);
    chk("rst_we", 32'(o_we), 32'd0);
    chk("rst_ld_ready", 32'(o_ld_ready), 32'd1);
    chk("rst_stall", 32'(o_stall), 32'd0);
    chk("rst_wb_hold", 32'(o_wb_hold), 32'd0);
    idle_inputs();
    i_rst_n = 1'b1;
    $display("step: reset released");

    // ALU write to r5, then an ALU result to r0 that must be dropped
    i_alu_valid = 1'b1; i_alu_rd = 5'd5; i_alu_data = 32'hDEADBEEF;
    cycle();
    i_alu_valid = 1'b0;
    chk("alu_we", 32'(o_we), 32'd1);
    chk("alu_waddr", 32'(o_waddr), 32'd5);
    chk("alu_wdata", o_wdata, 32'hDEADBEEF);
    $display("step: alu write r5 we=%0d waddr=%0d wdata=%h", o_we, o_waddr, o_wdata);
    i_alu_valid = 1'b1; i_alu_rd = 5'd0; i_alu_data = 32'h11111111;
    cycle();
    i_alu_valid = 1'b0;
    chk("alu_r0_we", 32'(o_we), 32'd0);
    $display("step: alu write r0 we=%0d", o_we);

    // Forwarding of the write presented this cycle
    i_alu_valid = 1'b1; i_alu_rd = 5'd3; i_alu_data = 32'h0000A5A5;
    cycle();
    i_alu_valid = 1'b0; i_raddr2 = 5'd3; i_rf_rdata2 = 32'd0;
`ifdef REGFILE_WB_FWD_EN
    fwd_exp = 32'h0000A5A5;
`else
    fwd_exp = 32'd0;
`endif
    #1;
    chk("fwd_rdata2", o_rdata2, fwd_exp);
    $display("step: forward check rdata2=%h", o_rdata2);
    cycle();
    idle_inputs();

    // Load hazard on r7, cleared by its return
    i_ld_issue = 1'b1; i_ld_issue_rd = 5'd7;
    cycle();
    i_ld_issue = 1'b0; i_raddr1 = 5'd7;
    #1;
    chk("hazard_stall", 32'(o_stall), 32'd1);
    $display("step: load r7 issued stall=%0d", o_stall);
    cycle();
    i_ld_valid = 1'b1; i_ld_rd = 5'd7; i_ld_data = 32'h00001234;
    cycle();
    i_ld_valid = 1'b0;
    cycle();
    chk("hazard_cleared", 32'(o_stall), 32'd0);
    chk("ld_we", 32'(o_we), 32'd1);
    chk("ld_waddr", 32'(o_waddr), 32'd7);
    chk("ld_wdata", o_wdata, 32'h00001234);
    $display("step: load r7 returned stall=%0d waddr=%0d wdata=%h", o_stall, o_waddr, o_wdata);
    idle_inputs();

    // Fill the queue under continuous ALU traffic, then starve it
    i_alu_valid = 1'b1; i_alu_rd = 5'd1;
    for (int k = 0; k < 4; k++) begin
      i_alu_data = $urandom;
      i_ld_valid = 1'b1; i_ld_rd = 5'(10 + k); i_ld_data = 32'hC0DE0000 + 32'(k);
      cycle();
    end
    i_ld_rd = 5'd20; i_ld_data = 32'h00005555;
    #1;
    chk("full_ld_ready", 32'(o_ld_ready), 32'd0);
    $display("step: four returns queued ld_ready=%0d", o_ld_ready);
    for (int k = 0; k < 5; k++) begin
      i_alu_data = $urandom;
      cycle();
    end
    chk("starve_hold", 32'(o_wb_hold), 32'd1);
    $display("step: eight lost cycles wb_hold=%0d", o_wb_hold);
    i_alu_valid = 1'b0;
    cycle();
    chk("bubble_hold_clear", 32'(o_wb_hold), 32'd0);
    chk("bubble_waddr", 32'(o_waddr), 32'd10);
    $display("step: alu bubble wb_hold=%0d waddr=%0d", o_wb_hold, o_waddr);
    cycle();
    i_ld_valid = 1'b0;
    seen20 = 1'b0;
    for (int k = 0; k < 8; k++) begin
      cycle();
      if (o_we && (o_waddr == 5'd20) && (o_wdata == 32'h00005555)) seen20 = 1'b1;
    end
    chk("held_return_written", 32'(seen20), 32'd1);
    $display("step: held fifth return written=%0d", seen20);

    // Random traffic against the model
    for (int n = 0; n < 500; n++) begin
      i_ld_issue    = ($urandom_range(3) == 0);
      i_ld_issue_rd = 5'($urandom_range(7));
      i_alu_valid   = (lost_m == STARVE_LIMIT) ? 1'b0 : 1'($urandom_range(1));
      i_alu_rd      = 5'($urandom_range(7));
      i_alu_data    = $urandom;
      i_ld_valid    = ($urandom_range(2) == 0);
      i_ld_rd       = 5'($urandom_range(7));
      i_ld_data     = $urandom;
      i_raddr1      = 5'($urandom_range(7));
      i_raddr2      = 5'($urandom_range(7));
      i_rf_rdata1   = $urandom;
      i_rf_rdata2   = $urandom;
      cycle();
    end
    $display("step: random phase done, queue model depth %0d", q.size());

    // Asynchronous reset mid-operation with loads outstanding
    idle_inputs();
    i_ld_issue = 1'b1; i_ld_issue_rd = 5'd9;
    cycle();
    i_ld_issue = 1'b0; i_ld_valid = 1'b1; i_ld_rd = 5'd9; i_ld_data = 32'hFACE;
    i_alu_valid = 1'b1; i_alu_rd = 5'd2; i_alu_data = 32'hBEEF;
    cycle();
    i_raddr1 = 5'd9;
    #2;
    i_rst_n = 1'b0;
    model_reset();
    #1;
    chk("arst_we", 32'(o_we), 32'd0);
    chk("arst_ld_ready", 32'(o_ld_ready), 32'd1);
    chk("arst_stall", 32'(o_stall), 32'd0);
    chk("arst_wb_hold", 32'(o_wb_hold), 32'd0);
    $display("step: async reset mid-operation we=%0d stall=%0d", o_we, o_stall);
    idle_inputs();
    @(negedge i_clk);
    i_rst_n = 1'b1;
    repeat (3) cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
